spi_cfg_master: RTL and testbench

Sequencing controller that drives the PWM register bank's SPI peripheral from on-chip logic. Accepts one register-write request at a time over a valid/ready handshake, serialises it into a 16-bit SPI mode-0 frame (R/W bit, 7-bit address, 8-bit data, MSB first), and spaces frames so the peripheral's 2-FF synchronisers and end-of-frame commit see every edge. Sits between the configuration/boot sequencer and the `SCLK`/`nCS`/`COPI` pins of the register bank.

---
 rtl/spi_cfg_pkg.sv | 25 ++
 rtl/spi_phase_timer.sv | 24 ++
 rtl/spi_cfg_master.sv | 152 +++++++++++++++
 tb/tb_spi_cfg_master.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM state type for the SPI configuration master.
package spi_cfg_pkg;

    // Register map of the PWM register bank
    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

    // Highest address the peripheral implements; anything above is rejected
    localparam logic [6:0] REG_ADDR_MAX = 7'h04;

    // R/W bit + 7-bit address + 8-bit data
    localparam int FRAME_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter; tc flags that the current phase is in its last cycle.
module spi_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       tc
);

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign tc = (count == 8'd0);

endmodule

// File: rtl/spi_cfg_master.sv
// Serialises single register-write requests into 16-bit SPI mode-0 frames
// with a guaranteed nCS-high gap between frames.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic [7:0]  tmr_count;
    logic        tmr_tc;
    logic        sclk_d, ncs_d, copi_d, done_d, err_d;

    spi_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // Next-state logic; pin values are computed one cycle ahead so every output is a flop
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmr_load  = 1'b0;
        tmr_val   = DIV_LOAD;
        sclk_d    = SCLK;
        ncs_d     = nCS;
        copi_d    = COPI;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    bit_cnt_d = 5'd0;
                    if (req_addr > REG_ADDR_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        shift_d  = {req_write, req_addr, req_data};
                        tmr_load = 1'b1;
                        ncs_d    = 1'b0;
                        sclk_d   = 1'b0;
                        copi_d   = req_write;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_tc) begin
                    state_d   = ST_HIGH;
                    tmr_load  = 1'b1;
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_HIGH: begin
                // Falling edge: present the next bit; zeros shift in behind the frame
                if (tmr_tc) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    sclk_d   = 1'b0;
                    shift_d  = {shift_q[14:0], 1'b0};
                    copi_d   = shift_q[14];
                end
            end
            ST_LOW: begin
                if (tmr_tc) begin
                    if (bit_cnt_q == 5'(FRAME_BITS)) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        ncs_d    = 1'b1;
                        copi_d   = 1'b0;
                    end else begin
                        state_d   = ST_HIGH;
                        tmr_load  = 1'b1;
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_GAP: begin
                // done lands in the final gap cycle
                if (tmr_count == 8'd1) begin
                    done_d = 1'b1;
                end
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset drives the pins to idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            SCLK      <= 1'b0;
            nCS       <= 1'b1;
            COPI      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            SCLK      <= sclk_d;
            nCS       <= ncs_d;
            COPI      <= copi_d;
            req_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Frame shift register is pure data; it is always reloaded at accept
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a behavioural register-bank peripheral.
module tb_spi_cfg_master;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: default timing
    logic va, wa, ready_a, done_a, err_a, busy_a, sclk_a, ncs_a, copi_a;
    logic [6:0] addr_a;
    logic [7:0] data_a;
    // Instance B: CLK_DIV=8, GAP_CYCLES=6
    logic vb, wb, ready_b, done_b, err_b, busy_b, sclk_b, ncs_b, copi_b;
    logic [6:0] addr_b;
    logic [7:0] data_b;

    spi_cfg_master u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(ready_a),
        .req_write(wa), .req_addr(addr_a), .req_data(data_a),
        .done(done_a), .err(err_a), .busy(busy_a),
        .SCLK(sclk_a), .nCS(ncs_a), .COPI(copi_a)
    );

    spi_cfg_master #(.CLK_DIV(8), .GAP_CYCLES(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(ready_b),
        .req_write(wb), .req_addr(addr_b), .req_data(data_b),
        .done(done_b), .err(err_b), .busy(busy_b),
        .SCLK(sclk_b), .nCS(ncs_b), .COPI(copi_b)
    );

    // Cycle-level monitors (old values seen at the edge = value during the ending cycle)
    int acc_a = 0, n_acc_a = 0, done_cyc_a = 0, n_done_a = 0, err_cyc_a = 0;
    int ncs_low_a = 0, hi_run_a = 0, last_hi_run_a = 0;
    int acc_b = 0, n_acc_b = 0, done_cyc_b = 0, n_done_b = 0, ncs_low_b = 0;

    always @(posedge clk) begin
        if (rst_n && va && ready_a) begin acc_a = cyc; n_acc_a++; end
        if (rst_n && vb && ready_b) begin acc_b = cyc; n_acc_b++; end
        if (done_a) begin done_cyc_a = cyc; n_done_a++; end
        if (done_b) begin done_cyc_b = cyc; n_done_b++; end
        if (err_a) err_cyc_a = cyc;
        if (!ncs_a) begin
            ncs_low_a++;
            if (hi_run_a > 0) last_hi_run_a = hi_run_a;
            hi_run_a = 0;
        end else begin
            hi_run_a++;
        end
        if (!ncs_b) ncs_low_b++;
        cyc++;
    end

    // Peripheral models: shift on SCLK rise, commit on nCS rise only for complete frames
    logic [15:0] sh_a = 16'h0, last_frame_a = 16'h0, sh_b = 16'h0, last_frame_b = 16'h0;
    int bits_a = 0, bits_b = 0, writes_a = 0, writes_b = 0, ncs_falls_a = 0;
    logic [7:0] regs_a [0:4];
    logic [7:0] regs_b [0:4];

    always @(negedge ncs_a) begin sh_a = 16'h0; bits_a = 0; ncs_falls_a++; end
    always @(posedge sclk_a) if (!ncs_a) begin sh_a = {sh_a[14:0], copi_a}; bits_a++; end
    always @(posedge ncs_a) begin
        if (bits_a == 16) begin
            last_frame_a = sh_a;
            if (sh_a[15] && sh_a[14:8] <= 7'h04) begin
                regs_a[int'(sh_a[14:8])] = sh_a[7:0];
                writes_a++;
            end
        end
        bits_a = 0;
    end

    always @(negedge ncs_b) begin sh_b = 16'h0; bits_b = 0; end
    always @(posedge sclk_b) if (!ncs_b) begin sh_b = {sh_b[14:0], copi_b}; bits_b++; end
    always @(posedge ncs_b) begin
        if (bits_b == 16) begin
            last_frame_b = sh_b;
            if (sh_b[15] && sh_b[14:8] <= 7'h04) begin
                regs_b[int'(sh_b[14:8])] = sh_b[7:0];
                writes_b++;
            end
        end
        bits_b = 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and return at the first falling edge after it is accepted
    task automatic req(input int inst, input logic w, input logic [6:0] a,
                       input logic [7:0] d, input bit hold, input string tag);
        int start;
        bit ok;
        @(negedge clk);
        if (inst == 0) begin start = n_acc_a; wa = w; addr_a = a; data_a = d; va = 1'b1; end
        else           begin start = n_acc_b; wb = w; addr_b = a; data_b = d; vb = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (inst == 0) ? (n_acc_a != start) : (n_acc_b != start);
        end
        check(tag, 32'(ok), 32'd1);
        if (!hold) begin
            if (inst == 0) va = 1'b0; else vb = 1'b0;
        end
    endtask

    task automatic wait_done(input int inst, input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = (inst == 0) ? (n_done_a >= target) : (n_done_b >= target);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    int a1, nd, wr0, falls0;

    initial begin
        for (int i = 0; i < 5; i++) begin regs_a[i] = 8'h00; regs_b[i] = 8'h00; end
        rst_n = 1'b0;
        va = 1'b0; wa = 1'b0; addr_a = 7'h0; data_a = 8'h0;
        vb = 1'b0; wb = 1'b0; addr_b = 7'h0; data_b = 8'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_sclk",  32'(sclk_a),  32'd0);
        check("rst_ncs",   32'(ncs_a),   32'd1);
        check("rst_copi",  32'(copi_a),  32'd0);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write 0x04 <= 0xA5
        ncs_low_a = 0;
        nd = n_done_a;
        req(0, 1'b1, 7'h04, 8'hA5, 1'b0, "a_accept");
        check("a_busy_mid",  32'(busy_a),  32'd1);
        check("a_ready_mid", 32'(ready_a), 32'd0);
        check("a_ncs_mid",   32'(ncs_a),   32'd0);
        wait_done(0, nd + 1, "a_done_seen");
        check("a_frame",     32'(last_frame_a), 32'h84A5);
        check("a_ncs_low",   32'(ncs_low_a), 32'd132);
        check("a_done_lat",  32'(done_cyc_a - acc_a), 32'd136);
        check("a_ready_end", 32'(ready_a), 32'd1);
        check("a_busy_end",  32'(busy_a),  32'd0);
        check("a_reg4",      32'(regs_a[4]), 32'hA5);

        // Back-to-back with req_valid held across done
        nd = n_done_a;
        req(0, 1'b1, 7'h00, 8'hFF, 1'b1, "b1_accept");
        a1 = acc_a;
        req(0, 1'b1, 7'h02, 8'h0F, 1'b0, "b2_accept");
        check("b_accept_gap", 32'(acc_a - a1), 32'd137);
        wait_done(0, nd + 2, "b_done_seen");
        check("b_reg0",   32'(regs_a[0]), 32'hFF);
        check("b_reg2",   32'(regs_a[2]), 32'h0F);
        check("b_hi_run", 32'(last_hi_run_a), 32'd5);

        // Illegal address is rejected without touching the bus
        falls0 = ncs_falls_a;
        wr0 = writes_a;
        req(0, 1'b1, 7'h05, 8'h33, 1'b0, "c_accept");
        check("c_err_pulse", 32'(err_a),   32'd1);
        check("c_ready",     32'(ready_a), 32'd1);
        @(negedge clk);
        check("c_err_lat",   32'(err_cyc_a - acc_a), 32'd1);
        check("c_err_clr",   32'(err_a),   32'd0);
        repeat (5) @(negedge clk);
        check("c_no_ncs",    32'(ncs_falls_a), 32'(falls0));
        check("c_no_write",  32'(writes_a), 32'(wr0));
        check("c_busy",      32'(busy_a),  32'd0);

        // Reset in the middle of a frame
        wr0 = writes_a;
        req(0, 1'b1, 7'h03, 8'h5A, 1'b0, "d_accept");
        repeat (59) @(negedge clk);
        check("d_pre_ncs",  32'(ncs_a),  32'd0);
        check("d_pre_copi", 32'(copi_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("d_rst_ncs",  32'(ncs_a),  32'd1);
        check("d_rst_sclk", 32'(sclk_a), 32'd0);
        check("d_rst_copi", 32'(copi_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("d_ready",    32'(ready_a), 32'd1);
        check("d_busy",     32'(busy_a),  32'd0);
        check("d_reg3",     32'(regs_a[3]), 32'h00);
        check("d_no_write", 32'(writes_a), 32'(wr0));

        // Slow instance, read request to 0x01
        ncs_low_b = 0;
        nd = n_done_b;
        req(1, 1'b0, 7'h01, 8'hC3, 1'b0, "e_accept");
        wait_done(1, nd + 1, "e_done_seen");
        check("e_ncs_low",   32'(ncs_low_b), 32'd264);
        check("e_done_lat",  32'(done_cyc_b - acc_b), 32'd270);
        check("e_first_bit", 32'(last_frame_b[15]), 32'd0);
        check("e_frame",     32'(last_frame_b), 32'h01C3);
        check("e_no_write",  32'(writes_b), 32'd0);
        check("e_ready",     32'(ready_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
